bit_run_meter: RTL and testbench
================================

// Module: bit_run_meter
// PURPOSE
//  Downstream consumer of a 1-bit serial stream (e.g. a TFF/flip-flop data_out).
//  Measures runs of consecutive equal bits and reports each completed run.
//  Each report carries the run value, run length and a saturation flag, with a 1-cycle valid strobe.
//  Sits between a single-bit sequential stage and any logging/checking logic.
// PARAMETERS
//  CNT_W   8   width of run-length counter and run_len/max_len outputs (>=2)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      reset, asynchronous, active-low
//  sample_en  in   1      1 = sample data_in on this rising edge
//  data_in    in   1      serial bit; must be 0/1 whenever sample_en=1
//  flush      in   1      1 = close current run now and report it
//  run_vld    out  1      1-cycle strobe: run_val/run_len/run_ovf hold a new report
//  run_val    out  1      bit value of reported run
//  run_len    out  CNT_W  length of reported run (samples)
//  run_ovf    out  1      1 = reported run saturated at 2^CNT_W-1
//  busy       out  1      1 = a run is open (state RUN)
//  max_len    out  CNT_W  longest reported run_len since reset (RUN_STATS_EN only)
// BEHAVIOUR
//  - Async reset: state=IDLE, cnt=0, cur_val=0, all outputs 0.
//    Reset during an open run discards it; no run_vld is issued.
//  - All outputs are registered. run_vld is high exactly one cycle after the closing edge, then low.
//  - run_val/run_len/run_ovf hold their last report until the next report.
//  - FSM IDLE: busy=0.
//      On sample_en=1: cur_val<=data_in, cnt<=1, go RUN.
//      flush in IDLE: ignored.
//  - FSM RUN: busy=1.
//      sample_en=0, flush=0: hold.
//      sample_en=1, data_in==cur_val: cnt<=cnt+1, saturating at 2^CNT_W-1.
//      sample_en=1, data_in!=cur_val: report (cur_val, cnt, cnt==2^CNT_W-1), then cur_val<=data_in, cnt<=1.
//        Stay in RUN; there is no idle gap between runs.
//      flush=1: report the current run and go IDLE. Flush has priority.
//        A sample_en=1 bit on the same edge is discarded, not counted.
//  - Saturation: cnt sticks at 2^CNT_W-1. Further equal bits are absorbed.
//    The report carries run_ovf=1 and run_len=2^CNT_W-1.
//  - Consecutive reports on back-to-back edges (alternating bits) give run_vld high on consecutive cycles, each with run_len=1.
//  - Minimum reported run_len is 1. A report with run_len=0 never occurs.
// CONFIGURATION
//  RUN_STATS_EN defined:
//    max_len port exists, reset to 0.
//    Updated on the same edge as each report: max_len<=run_len if run_len>max_len (before saturation check: saturated reports update with 2^CNT_W-1).
//    Cleared only by rst_n.
//  RUN_STATS_EN undefined:
//    max_len port and its logic are absent.
//    All other behaviour is identical.
// TESTING (clk period 20 ns, CNT_W=8)
//  T1 reset: hold rst_n=0 with data_in=x and sample_en=0.
//    -> all outputs 0, busy=0. No X on any output.
//  T2 stream: after rst_n rises, sample_en=1 with bits 1,0,1,1,0,0,1,1,1,0,0,0,0, then flush.
//    -> reports (1,1),(0,1),(1,2),(0,2),(1,3),(0,4); run_ovf=0 throughout; busy=0 after flush.
//  T3 saturation: CNT_W=4, 20 ones then one 0.
//    -> single report run_val=1, run_len=15, run_ovf=1.
//  T4 simultaneous: in RUN (cur_val=1, cnt=3), assert flush and sample_en with data_in=1 on the same edge.
//    -> report run_len=3, state IDLE, the sampled bit is not counted.
//  T5 gaps and reset: sample_en toggles 1/0 over bits 1,1,1 with idle cycles between.
//    -> no report, cnt=3. Then pulse rst_n=0 mid-run -> no run_vld, busy=0.
//  T6 RUN_STATS_EN: after T2 -> max_len=4.
//    A subsequent run of 2 -> max_len stays 4. Reset -> max_len=0.

Source files
------------

// File: rtl/bit_run_meter.sv
// Run-length meter for a 1-bit serial stream: reports value, length and saturation of each run.
// Optional RUN_STATS_EN adds max_len, the longest run reported since reset.
module bit_run_meter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic             data_in,
  input  logic             flush,
  output logic             run_vld,
  output logic             run_val,
  output logic [CNT_W-1:0] run_len,
  output logic             run_ovf,
`ifdef RUN_STATS_EN
  output logic [CNT_W-1:0] max_len,
`endif
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             cur_val_q, cur_val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_vld_q, run_vld_d;
  logic             run_val_q, run_val_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic             run_ovf_q, run_ovf_d;
  logic             busy_q, busy_d;
  logic             report;
`ifdef RUN_STATS_EN
  logic [CNT_W-1:0] max_len_q, max_len_d;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cur_val_q <= 1'b0;
      cnt_q     <= '0;
      run_vld_q <= 1'b0;
      run_val_q <= 1'b0;
      run_len_q <= '0;
      run_ovf_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef RUN_STATS_EN
      max_len_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cur_val_q <= cur_val_d;
      cnt_q     <= cnt_d;
      run_vld_q <= run_vld_d;
      run_val_q <= run_val_d;
      run_len_q <= run_len_d;
      run_ovf_q <= run_ovf_d;
      busy_q    <= busy_d;
`ifdef RUN_STATS_EN
      max_len_q <= max_len_d;
`endif
    end
  end

  // Next-state, run counting and report generation
  always_comb begin
    state_d   = state_q;
    cur_val_d = cur_val_q;
    cnt_d     = cnt_q;
    run_vld_d = 1'b0;
    run_val_d = run_val_q;
    run_len_d = run_len_q;
    run_ovf_d = run_ovf_q;
    report    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sample_en) begin
          cur_val_d = data_in;
          cnt_d     = CNT_ONE;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        // Flush wins; a bit sampled on the same edge is dropped
        if (flush) begin
          report  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (sample_en) begin
          if (data_in == cur_val_q) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
          end else begin
            report    = 1'b1;
            cur_val_d = data_in;
            cnt_d     = CNT_ONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (report) begin
      run_vld_d = 1'b1;
      run_val_d = cur_val_q;
      run_len_d = cnt_q;
      run_ovf_d = (cnt_q == CNT_MAX);
    end

    busy_d = (state_d == S_RUN);
  end

`ifdef RUN_STATS_EN
  // Longest reported run, tracked alongside the report itself
  always_comb begin
    max_len_d = max_len_q;
    if (report && (cnt_q > max_len_q)) max_len_d = cnt_q;
  end

  assign max_len = max_len_q;
`endif

  assign run_vld = run_vld_q;
  assign run_val = run_val_q;
  assign run_len = run_len_q;
  assign run_ovf = run_ovf_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_bit_run_meter.sv
// Directed bench for bit_run_meter: CNT_W=8 instance for stream/flush/reset cases, CNT_W=4 for saturation.
module tb_bit_run_meter;

  logic       clk;
  logic       rst_n;
  logic       se8, d8, fl8;
  logic       vld8, val8, ovf8, busy8;
  logic [7:0] len8;
  logic       se4, d4, fl4;
  logic       vld4, val4, ovf4, busy4;
  logic [3:0] len4;
`ifdef RUN_STATS_EN
  logic [7:0] max8;
  logic [3:0] max4;
`endif

  int n_vec;
  int n_bad;

  typedef struct {
    logic       se;
    logic       d;
    logic       fl;
    logic       vld;
    logic       val;
    logic [7:0] len;
    logic       ovf;
    logic       busy;
    string      name;
  } vec_t;

  vec_t vq[$];

  bit_run_meter #(.CNT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .sample_en(se8), .data_in(d8), .flush(fl8),
    .run_vld(vld8), .run_val(val8), .run_len(len8), .run_ovf(ovf8),
`ifdef RUN_STATS_EN
    .max_len(max8),
`endif
    .busy(busy8)
  );

  bit_run_meter #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .sample_en(se4), .data_in(d4), .flush(fl4),
    .run_vld(vld4), .run_val(val4), .run_len(len4), .run_ovf(ovf4),
`ifdef RUN_STATS_EN
    .max_len(max4),
`endif
    .busy(busy4)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic se, input logic d, input logic fl,
                              input logic vld, input logic val, input logic [7:0] len,
                              input logic ovf, input logic busy, input string name);
    vec_t v;
    v.se = se; v.d = d; v.fl = fl;
    v.vld = vld; v.val = val; v.len = len; v.ovf = ovf; v.busy = busy; v.name = name;
    vq.push_back(v);
  endfunction

  task automatic step8(input logic se, input logic d, input logic fl);
    se8 = se; d8 = d; fl8 = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic step4(input logic se, input logic d, input logic fl);
    se4 = se; d4 = d; fl4 = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack8();
    return {20'd0, vld8, val8, ovf8, busy8, len8};
  endfunction

  function automatic logic [31:0] pack4();
    return {24'd0, vld4, val4, ovf4, busy4, len4};
  endfunction

  function automatic logic [31:0] exp8(input logic vld, input logic val, input logic [7:0] len,
                                       input logic ovf, input logic busy);
    return {20'd0, vld, val, ovf, busy, len};
  endfunction

  initial begin
    logic any_vld;
    n_vec = 0;
    n_bad = 0;

    // stream 1,0,1,1,0,0,1,1,1,0,0,0,0 then flush
    add(1,1,0, 0,0,8'd0,0,1, "t2_open");
    add(1,0,0, 1,1,8'd1,0,1, "t2_r1");
    add(1,1,0, 1,0,8'd1,0,1, "t2_r2");
    add(1,1,0, 0,0,8'd1,0,1, "t2_c2");
    add(1,0,0, 1,1,8'd2,0,1, "t2_r3");
    add(1,0,0, 0,1,8'd2,0,1, "t2_c3");
    add(1,1,0, 1,0,8'd2,0,1, "t2_r4");
    add(1,1,0, 0,0,8'd2,0,1, "t2_c4a");
    add(1,1,0, 0,0,8'd2,0,1, "t2_c4b");
    add(1,0,0, 1,1,8'd3,0,1, "t2_r5");
    add(1,0,0, 0,1,8'd3,0,1, "t2_c5a");
    add(1,0,0, 0,1,8'd3,0,1, "t2_c5b");
    add(1,0,0, 0,1,8'd3,0,1, "t2_c5c");
    add(0,0,1, 1,0,8'd4,0,0, "t2_flush");
    add(0,0,1, 0,0,8'd4,0,0, "idle_flush_ignored");
    add(0,0,0, 0,0,8'd4,0,0, "idle_hold");
    // flush together with a matching sample after three ones
    add(1,1,0, 0,0,8'd4,0,1, "t4_open");
    add(0,0,0, 0,0,8'd4,0,1, "t4_hold");
    add(1,1,0, 0,0,8'd4,0,1, "t4_c2");
    add(1,1,0, 0,0,8'd4,0,1, "t4_c3");
    add(1,1,1, 1,1,8'd3,0,0, "t4_simul");
    add(0,0,0, 0,1,8'd3,0,0, "t4_idle");
    add(1,1,0, 0,1,8'd3,0,1, "t4_reopen");
    add(0,0,1, 1,1,8'd1,0,0, "t4_len1");
    // run of two zeros
    add(1,0,0, 0,1,8'd1,0,1, "t6_open");
    add(1,0,0, 0,1,8'd1,0,1, "t6_c2");
    add(0,0,1, 1,0,8'd2,0,0, "t6_flush");

    // reset with data_in unknown
    rst_n = 1'b0;
    se8 = 1'b0; d8 = 1'bx; fl8 = 1'b0;
    se4 = 1'b0; d4 = 1'bx; fl4 = 1'b0;
    #35;
    chk("t1_reset8", pack8(), 32'd0);
    chk("t1_reset4", pack4(), 32'd0);
    chk("t1_noX", {31'd0, $isunknown({vld8, val8, len8, ovf8, busy8, vld4, val4, len4, ovf4, busy4})}, 32'd0);
`ifdef RUN_STATS_EN
    chk("t1_max8", {24'd0, max8}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    d8 = 1'b0; d4 = 1'b0;

    foreach (vq[i]) begin
      step8(vq[i].se, vq[i].d, vq[i].fl);
      chk(vq[i].name, pack8(), exp8(vq[i].vld, vq[i].val, vq[i].len, vq[i].ovf, vq[i].busy));
`ifdef RUN_STATS_EN
      if (vq[i].name == "t2_flush") chk("t6_max_after_t2", {24'd0, max8}, 32'd4);
`endif
    end
`ifdef RUN_STATS_EN
    chk("t6_max_kept", {24'd0, max8}, 32'd4);
`endif

    // sparse samples of ones with idle gaps: no report, run length still 3
    any_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step8(1, 1, 0);
      any_vld |= vld8;
      step8(0, 0, 0);
      any_vld |= vld8;
    end
    chk("t5_gap_novld", {31'd0, any_vld}, 32'd0);
    chk("t5_gap_busy", {31'd0, busy8}, 32'd1);
    step8(1, 0, 0);
    chk("t5_gap_len3", pack8(), exp8(1, 1, 8'd3, 0, 1));
    step8(1, 0, 0);
    chk("t5_midrun", pack8(), exp8(0, 1, 8'd3, 0, 1));
    se8 = 1'b0;
    rst_n = 1'b0;
    #4;
    chk("t5_async_rst", pack8(), 32'd0);
`ifdef RUN_STATS_EN
    chk("t6_max_rst", {24'd0, max8}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step8(0, 0, 0);
    chk("t5_post_rst", pack8(), 32'd0);
    step8(0, 0, 1);
    chk("t5_post_rst_flush", pack8(), 32'd0);

    // saturation on the 4-bit instance
    any_vld = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step4(1, 1, 0);
      any_vld |= vld4;
    end
    chk("t3_novld", {31'd0, any_vld}, 32'd0);
    step4(1, 0, 0);
    chk("t3_sat", pack4(), {24'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd15});
    step4(0, 0, 0);
    chk("t3_hold", pack4(), {24'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd15});
    step4(0, 0, 1);
    chk("t3_flush", pack4(), {24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1});
`ifdef RUN_STATS_EN
    chk("t3_max4", {28'd0, max4}, 32'd15);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
